// File: rtl/can_stuff_engine.sv
// CAN / CAN FD bit-stuffing engine: inserts stuff bits on TX, removes and checks them on RX,
// and keeps the frame's stuff-bit count in binary, Gray code and Gray parity.
module can_stuff_engine #(
    parameter int RUN_LEN     = 5,
    parameter int STUFF_CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   frame_start,
    input  logic                   stuff_en,
    input  logic                   sample_point,
    input  logic                   bit_in,
    output logic                   bit_out,
    output logic                   data_ack,
    output logic                   data_valid,
    output logic                   stuff_bit,
    output logic                   stuff_err,
    output logic [STUFF_CNT_W-1:0] stuff_cnt,
    output logic [STUFF_CNT_W-1:0] stuff_cnt_gray,
    output logic                   stuff_cnt_par
);

    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);
    localparam logic [STUFF_CNT_W-1:0] CNT_ONE = STUFF_CNT_W'(1);

    localparam logic MODE_TX = 1'b0;

    // Handshake: the engine advances only on a one-cycle sample_point strobe. In TX, data_ack
    // pulses the cycle after a slot that consumed bit_in; when it stays low the framer must
    // hold bit_in for the next strobe. In RX, data_valid marks bit_out as a de-stuffed data bit.

    logic                   prev_bit;
    logic [RW-1:0]          run_cnt;
    logic                   mode_q;

    logic                   cur_prev;
    logic [RW-1:0]          cur_run;
    logic                   cur_mode;
    logic [STUFF_CNT_W-1:0] cur_cnt;
    logic                   cur_err;

    logic                   nxt_prev;
    logic [RW-1:0]          nxt_run;
    logic [STUFF_CNT_W-1:0] nxt_cnt;
    logic [STUFF_CNT_W-1:0] nxt_gray;
    logic                   nxt_par;
    logic                   nxt_err;
    logic                   nxt_out;
    logic                   nxt_ack;
    logic                   nxt_valid;
    logic                   nxt_sb;

    // frame_start clears the state first, so a coincident strobe is bit 1 of the new frame.
    always_comb begin
        cur_prev = frame_start ? 1'b1 : prev_bit;
        cur_run  = frame_start ? '0 : run_cnt;
        cur_mode = frame_start ? mode : mode_q;
        cur_cnt  = frame_start ? '0 : stuff_cnt;
        cur_err  = frame_start ? 1'b0 : stuff_err;
    end

    always_comb begin
        nxt_prev  = cur_prev;
        nxt_run   = cur_run;
        nxt_cnt   = cur_cnt;
        nxt_err   = cur_err;
        nxt_out   = bit_out;
        nxt_ack   = 1'b0;
        nxt_valid = 1'b0;
        nxt_sb    = 1'b0;

        if (sample_point) begin
            if (!stuff_en) begin
                nxt_out   = bit_in;
                nxt_ack   = (cur_mode == MODE_TX);
                nxt_valid = (cur_mode != MODE_TX);
                nxt_prev  = bit_in;
                nxt_run   = '0;
            end else if (cur_run == RUN_MAX) begin
                if (cur_mode == MODE_TX) begin
                    nxt_out  = ~cur_prev;
                    nxt_sb   = 1'b1;
                    nxt_prev = ~cur_prev;
                    nxt_run  = RUN_ONE;
                    nxt_cnt  = cur_cnt + CNT_ONE;
                end else begin
                    nxt_out  = bit_in;
                    nxt_prev = bit_in;
                    nxt_run  = RUN_ONE;
                    if (bit_in != cur_prev) begin
                        nxt_sb  = 1'b1;
                        nxt_cnt = cur_cnt + CNT_ONE;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end else begin
                nxt_out   = bit_in;
                nxt_ack   = (cur_mode == MODE_TX);
                nxt_valid = (cur_mode != MODE_TX);
                nxt_prev  = bit_in;
                nxt_run   = (cur_run == '0 || bit_in != cur_prev) ? RUN_ONE : cur_run + RUN_ONE;
            end
        end

        nxt_gray = nxt_cnt ^ (nxt_cnt >> 1);
        nxt_par  = ^nxt_gray;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit       <= 1'b1;
            run_cnt        <= '0;
            mode_q         <= MODE_TX;
            bit_out        <= 1'b1;
            data_ack       <= 1'b0;
            data_valid     <= 1'b0;
            stuff_bit      <= 1'b0;
            stuff_err      <= 1'b0;
            stuff_cnt      <= '0;
            stuff_cnt_gray <= '0;
            stuff_cnt_par  <= 1'b0;
        end else begin
            prev_bit       <= nxt_prev;
            run_cnt        <= nxt_run;
            mode_q         <= cur_mode;
            bit_out        <= nxt_out;
            data_ack       <= nxt_ack;
            data_valid     <= nxt_valid;
            stuff_bit      <= nxt_sb;
            stuff_err      <= nxt_err;
            stuff_cnt      <= nxt_cnt;
            stuff_cnt_gray <= nxt_gray;
            stuff_cnt_par  <= nxt_par;
        end
    end

endmodule

// File: tb/tb_can_stuff_engine.sv
// Bench for can_stuff_engine: directed scenarios plus randomized traffic, every cycle
// compared against a bus-history reference model of the stuffing rules.
module tb_can_stuff_engine;

    localparam int RUN_LEN = 5;
    localparam int CW      = 3;
    localparam int W       = 12;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          frame_start;
    logic          stuff_en;
    logic          sample_point;
    logic          bit_in;
    logic          bit_out;
    logic          data_ack;
    logic          data_valid;
    logic          stuff_bit;
    logic          stuff_err;
    logic [CW-1:0] stuff_cnt;
    logic [CW-1:0] stuff_cnt_gray;
    logic          stuff_cnt_par;
    logic [W-1:0]  dut_vec;

    can_stuff_engine #(.RUN_LEN(RUN_LEN), .STUFF_CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode           (mode),
        .frame_start    (frame_start),
        .stuff_en       (stuff_en),
        .sample_point   (sample_point),
        .bit_in         (bit_in),
        .bit_out        (bit_out),
        .data_ack       (data_ack),
        .data_valid     (data_valid),
        .stuff_bit      (stuff_bit),
        .stuff_err      (stuff_err),
        .stuff_cnt      (stuff_cnt),
        .stuff_cnt_gray (stuff_cnt_gray),
        .stuff_cnt_par  (stuff_cnt_par)
    );

    assign dut_vec = {bit_out, data_ack, data_valid, stuff_bit, stuff_err,
                      stuff_cnt, stuff_cnt_gray, stuff_cnt_par};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: bus bits of the current run segment, stuff slot when the tail holds
    // RUN_LEN identical bits.
    bit m_seg[$];
    bit m_mode;
    int m_cnt;
    bit m_err;
    bit m_out;
    bit m_ack;
    bit m_valid;
    bit m_sb;

    function automatic int tail_run();
        int n;
        n = 0;
        if (m_seg.size() == 0) return 0;
        for (int i = m_seg.size() - 1; i >= 0; i--) begin
            if (m_seg[i] == m_seg[m_seg.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] m_vec();
        logic [CW-1:0] c;
        logic [CW-1:0] g;
        logic          p;
        c = CW'(m_cnt);
        g = c ^ (c >> 1);
        p = 1'b0;
        for (int i = 0; i < CW; i++) p = p ^ g[i];
        return {m_out, m_ack, m_valid, m_sb, m_err, c, g, p};
    endfunction

    task automatic model_reset();
        m_seg.delete();
        m_mode = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_out  = 1'b1;
        m_ack  = 1'b0;
        m_valid = 1'b0;
        m_sb   = 1'b0;
    endtask

    task automatic model_step(input bit fs, input bit md, input bit sp, input bit en, input bit b);
        bit last;
        if (fs) begin
            m_seg.delete();
            m_mode = md;
            m_cnt  = 0;
            m_err  = 1'b0;
        end
        m_ack = 1'b0;
        m_valid = 1'b0;
        m_sb = 1'b0;
        if (sp) begin
            if (!en) begin
                m_out = b;
                m_ack = !m_mode;
                m_valid = m_mode;
                m_seg.delete();
            end else if (tail_run() == RUN_LEN) begin
                last = m_seg[m_seg.size() - 1];
                m_seg.delete();
                if (!m_mode) begin
                    m_out = !last;
                    m_sb  = 1'b1;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    m_seg.push_back(!last);
                end else begin
                    m_out = b;
                    m_seg.push_back(b);
                    if (b != last) begin
                        m_sb  = 1'b1;
                        m_cnt = (m_cnt + 1) % (1 << CW);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                m_out = b;
                m_ack = !m_mode;
                m_valid = m_mode;
                m_seg.push_back(b);
                if (m_seg.size() > 32) void'(m_seg.pop_front());
            end
        end
    endtask

    // scoreboard checks
    task automatic chkv(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic act, input logic exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    // driver: one clock cycle, entered and left on a falling edge
    task automatic cyc(input bit fs, input bit md, input bit sp, input bit en, input bit b);
        frame_start  = fs;
        mode         = md;
        sample_point = sp;
        stuff_en     = en;
        bit_in       = b;
        model_step(fs, md, sp, en, b);
        exp_q.push_back(m_vec());
        @(posedge clk);
        #1;
        chkv("scoreboard", dut_vec, exp_q.pop_front());
        @(negedge clk);
        frame_start  = 1'b0;
        sample_point = 1'b0;
    endtask

    task automatic strobe(input bit en, input bit b);
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, en, b);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chkv("reset_async", dut_vec, 12'h800);
        @(posedge clk);
        #1;
        chkv("reset_hold", dut_vec, m_vec());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  t1_out;
        logic [10:0] t2_out;
        logic [8:0]  t2_data;
        logic [6:0]  t3_bus;
        int          k;
        int          n_sb;
        int          guard;

        t1_out  = 8'b0010_0000;
        t2_out  = 11'b011_1110_0000;
        t2_data = 9'b1_1110_0000;
        t3_bus  = 7'b101_1111;

        rst_n = 1'b0;
        mode = 1'b0;
        frame_start = 1'b0;
        stuff_en = 1'b0;
        sample_point = 1'b0;
        bit_in = 1'b0;
        @(negedge clk);
        apply_reset();

        // 1: TX run of zeros
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, 1'b0);
            chk1("t1_bit_out", bit_out, t1_out[i]);
            chk1("t1_data_ack", data_ack, (i != 5));
        end
        chkc("t1_cnt", stuff_cnt, 3'd1);
        chkc("t1_gray", stuff_cnt_gray, 3'b001);
        chk1("t1_par", stuff_cnt_par, 1'b1);

        // 2: stuff bit joins the next run; framer advances on data_ack
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        k = 0;
        for (int i = 0; i < 11; i++) begin
            strobe(1'b1, (k < 9) ? t2_data[k] : 1'b1);
            chk1("t2_bit_out", bit_out, t2_out[i]);
            if (data_ack) k++;
        end
        chkc("t2_cnt", stuff_cnt, 3'd2);
        chkc("t2_gray", stuff_cnt_gray, 3'b011);
        chk1("t2_par", stuff_cnt_par, 1'b0);

        // 3: RX valid stuff bit
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            strobe(1'b1, t3_bus[i]);
            chk1("t3_data_valid", data_valid, (i != 5));
            chk1("t3_stuff_bit", stuff_bit, (i == 5));
        end
        chk1("t3_err", stuff_err, 1'b0);
        chkc("t3_cnt", stuff_cnt, 3'd1);

        // 4: RX stuff error is sticky until frame_start
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            strobe(1'b1, 1'b0);
            chk1("t4_err_rise", stuff_err, (i == 5));
        end
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'($urandom_range(0, 1)));
            chk1("t4_err_sticky", stuff_err, 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk1("t4_err_clear", stuff_err, 1'b0);

        // 5: counter wrap after nine TX stuff slots, then pass-through
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_sb = 0;
        guard = 0;
        while (n_sb < 9 && guard < 100) begin
            strobe(1'b1, m_out);
            if (stuff_bit) n_sb++;
            guard++;
        end
        chk1("t5_budget", (guard < 100), 1'b1);
        chkc("t5_cnt_wrap", stuff_cnt, 3'd1);
        chkc("t5_gray_wrap", stuff_cnt_gray, 3'b001);
        for (int i = 0; i < 10; i++) begin
            strobe(1'b0, 1'b0);
            chk1("t5_pass_bit", bit_out, 1'b0);
            chk1("t5_pass_sb", stuff_bit, 1'b0);
            chk1("t5_pass_ack", data_ack, 1'b1);
        end

        // 6: frame_start with coincident strobe restarts the run
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chkc("t6_fs_cnt", stuff_cnt, 3'd0);
        chk1("t6_fs_ack", data_ack, 1'b1);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 1'b0);
            chk1("t6_run_ack", data_ack, 1'b1);
        end
        strobe(1'b1, 1'b0);
        chk1("t6_stuff", stuff_bit, 1'b1);
        chk1("t6_stuff_out", bit_out, 1'b1);

        // 6b: reset mid-run in RX returns to TX
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1);
        apply_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk1("t6_reset_tx_ack", data_ack, 1'b1);
        chk1("t6_reset_tx_valid", data_valid, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit fs;
            bit sp;
            bit en;
            bit b;
            fs = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 19) != 0);
            b  = ($urandom_range(0, 4) == 0) ? !m_out : m_out;
            cyc(fs, 1'($urandom_range(0, 1)), sp, en, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/can_stuff_engine.md
# can_stuff_engine

Parametrised bidirectional bit-stuffing engine for the CAN/CAN FD bit path. In TX mode it inserts a complementary stuff bit after RUN_LEN identical bits and back-pressures the framer during the stuff slot. In RX mode it removes stuff bits, flags stuff errors and reports data bits only. It sits between the frame (de)serialiser and the bit-timing logic, advancing on the bit-timing `sample_point` strobe. It also keeps the CAN FD stuff-bit count in binary, Gray code and with parity.

## Interface
- RUN_LEN, 5, identical consecutive bits that trigger a stuff slot; legal range 2..15.
- STUFF_CNT_W, 3, width of the stuff-bit counter; the counter wraps modulo 2^STUFF_CNT_W.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = TX (insert), 1 = RX (remove/check); latched only on `frame_start`.
- frame_start  in  1  synchronous one-cycle pulse that starts a new frame.
- stuff_en  in  1  stuffing region active; sampled with `sample_point`.
- sample_point  in  1  one-cycle bit strobe.
- bit_in  in  1  TX: next framer data bit; RX: sampled bus bit.
- bit_out  out  1  TX: bit to drive on the bus; RX: last received bit.
- data_ack  out  1  TX: pulse, `bit_in` was consumed in the last slot.
- data_valid  out  1  RX: pulse, `bit_out` is a data bit (not a stuff bit).
- stuff_bit  out  1  pulse, the last slot was a stuff slot (both modes).
- stuff_err  out  1  RX: sticky stuff error; cleared by `frame_start` or reset.
- stuff_cnt  out  STUFF_CNT_W  count of valid stuff bits since `frame_start`.
- stuff_cnt_gray  out  STUFF_CNT_W  Gray code of `stuff_cnt`.
- stuff_cnt_par  out  1  XOR of all `stuff_cnt_gray` bits.

## Operation
Internal state:
- `prev_bit`, reset 1.
- `run_cnt`, width clog2(RUN_LEN+1), reset 0.
- `mode_q`, reset 0 (TX).

`frame_start` behaviour:
- Sets `run_cnt`=0 and `prev_bit`=1.
- Latches `mode`, clears `stuff_cnt` and clears `stuff_err`.
- If `sample_point` is high in the same cycle, that strobe is processed on the cleared state as the first bit of the new frame.

Run update for a data bit b:
- If `run_cnt`==0 or b!=`prev_bit`, then `run_cnt`=1.
- Otherwise `run_cnt`+1.
- `prev_bit`=b.

Per `sample_point` with `stuff_en`=1, a stuff slot is any slot where `run_cnt`==RUN_LEN. `run_cnt` never exceeds RUN_LEN.
- TX, stuff slot:
  - `bit_out`=~`prev_bit`; `stuff_bit` pulses; `data_ack` stays 0, so the framer holds `bit_in`.
  - `prev_bit`=~`prev_bit`, `run_cnt`=1, `stuff_cnt`+1.
  - The stuff bit counts toward the next run.
- TX, data slot: `bit_out`=`bit_in`; `data_ack` pulses; run update.
- RX, stuff slot, `bit_in`!=`prev_bit`: valid stuff bit. `stuff_bit` pulses, `data_valid` stays 0, `stuff_cnt`+1, `prev_bit`=`bit_in`, `run_cnt`=1.
- RX, stuff slot, `bit_in`==`prev_bit`: `stuff_err` is set. `stuff_bit` and `data_valid` stay 0, `stuff_cnt` is unchanged, `run_cnt`=1, `prev_bit`=`bit_in`.
- RX, data slot: `bit_out`=`bit_in`; `data_valid` pulses; run update.

Per `sample_point` with `stuff_en`=0:
- Pass-through: `bit_out`=`bit_in`.
- `data_ack` pulses in TX; `data_valid` pulses in RX.
- No stuff slot and no error; `run_cnt`=0.

Other rules:
- `mode` changes outside `frame_start` are ignored.
- `stuff_cnt` wraps from 2^STUFF_CNT_W-1 to 0.
- Gray code is `stuff_cnt` ^ (`stuff_cnt`>>1).

## Timing
- All outputs are registered and change in the cycle after the `sample_point` (or `frame_start`) that caused them.
- Pulse outputs are exactly one cycle wide. `bit_out` holds until the next strobe.
- Reset values:
  - `bit_out`=1.
  - `data_ack`, `data_valid`, `stuff_bit`, `stuff_err` = 0.
  - `stuff_cnt`, `stuff_cnt_gray`, `stuff_cnt_par` = 0.
- Reset mid-frame aborts immediately, with no flush.
- No strobe means no state change, apart from `frame_start` clears.
- Back-to-back strobes on consecutive cycles must be supported.

## Test plan
Tests use RUN_LEN=5, STUFF_CNT_W=3.
1. TX: `frame_start`(mode=0), `bit_in`=0 for 8 strobes.
   - Required: `bit_out` 0,0,0,0,0,1,0,0.
   - Required: `data_ack` low only after strobe 6.
   - Required: `stuff_cnt`=1, gray=001, par=1.
2. TX stuff bit joins the run: data 0,0,0,0,0,1,1,1,1,x.
   - Required: `bit_out` 0,0,0,0,0,1(stuff),1,1,1,1,0(stuff).
   - Required: `stuff_cnt`=2, gray=011, par=0.
3. RX: `frame_start`(mode=1), bus 1,1,1,1,1,0,1.
   - Required: `data_valid` on strobes 1-5 and 7; `stuff_bit` on strobe 6.
   - Required: `stuff_err`=0, `stuff_cnt`=1.
4. RX error: six 0s.
   - Required: `stuff_err` rises one cycle after strobe 6 and stays high across further strobes.
   - Required: the next `frame_start` clears it to 0.
5. Wrap and `stuff_en`:
   - Nine TX stuff slots give `stuff_cnt`=1, gray=001.
   - With `stuff_en`=0, ten 0s pass unchanged, with no `stuff_bit` and `data_ack` on every strobe.
6. Priority and reset:
   - `frame_start` with `sample_point` in the same cycle: the bit counts as run 1 of the new frame and `stuff_cnt` is 0.
   - `rst_n` low mid-run: all outputs at reset values next cycle, and `mode_q`=TX.
